vec_operand_packer: RTL and testbench

//   Serial-to-parallel operand packer feeding the adder_tree reduction input. It accepts
//   one WIDTH-bit element per cycle over a valid/ready stream and packs N elements into
//   one N*WIDTH vector. Short vectors (ended by s_last) are zero-padded. Sits between an

---
 rtl/vec_operand_packer.sv | 155 +++++++++++++++
 tb/tb_vec_operand_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_operand_packer.sv
// vec_operand_packer
//   Serial-to-parallel operand packer. Accepts one WIDTH-bit element per cycle
//   on a valid/ready stream and packs up to N elements into one N*WIDTH vector
//   for the adder tree. Vectors closed early by s_last are zero-padded above
//   the last populated lane.
//
//   Optional feature macro: VEC_PACK_MASK_EN
//     defined   -> adds output m_mask[N], bit k set iff lane k is populated.
//     undefined -> no m_mask port and no mask logic.
module vec_operand_packer #(
    parameter int WIDTH = 32,
    parameter int N     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [N*WIDTH-1:0]       m_data,
    output logic [$clog2(N):0]       m_count
`ifdef VEC_PACK_MASK_EN
    ,
    output logic [N-1:0]             m_mask
`endif
);

    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    // FILL: collecting elements. PEND: a complete vector waits for the output slot.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     fill_q [N];
    logic [WIDTH-1:0]     fill_next [N];
    logic [IW-1:0]        idx_q;
    logic [CW-1:0]        pend_count_q;

    logic                 beat_acc;
    logic                 beat_done;
    logic [CW-1:0]        beat_count;
    logic                 slot_free;
    logic                 load_vec;
    logic [CW-1:0]        load_count;
    logic [N*WIDTH-1:0]   load_data;
`ifdef VEC_PACK_MASK_EN
    logic [N-1:0]         load_mask;
`endif

    // s_ready decodes the registered state only, so m_ready never reaches it combinationally.
    assign s_ready    = (state_q == ST_FILL);
    assign beat_acc   = s_valid && s_ready;
    assign beat_done  = beat_acc && (s_last || (idx_q == IW'(N - 1)));
    assign beat_count = CW'(idx_q) + CW'(1);
    assign slot_free  = !m_valid || m_ready;
    assign load_vec   = slot_free && ((state_q == ST_PEND) || beat_done);
    assign load_count = (state_q == ST_PEND) ? pend_count_q : beat_count;

    // Fill buffer as it will look after this cycle's beat (lets a completing beat go straight out).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        for (int k = 0; k < N; k++) begin
            fill_next[k] = fill_q[k];
        end
        if (beat_acc) begin
            fill_next[idx_q] = s_data;
        end
    end

    // Assemble the outgoing vector: lanes at or above the count are forced to zero.
    always_comb begin
        load_data = '0;
        for (int k = 0; k < N; k++) begin
            if (CW'(k) < load_count) begin
                load_data[k*WIDTH +: WIDTH] = fill_next[k];
            end
        end
    end

`ifdef VEC_PACK_MASK_EN
    // Populated-lane mask for the outgoing vector.
    always_comb begin
        load_mask = '0;
        for (int k = 0; k < N; k++) begin
            load_mask[k] = (CW'(k) < load_count);
        end
    end
`endif

    // Next-state logic: park in PEND when a vector completes but the output slot is busy.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: if (beat_done && !slot_free) state_d = ST_PEND;
            ST_PEND: if (slot_free)               state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // State register, lane index and the count of a parked vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= ST_FILL;
            idx_q        <= '0;
            pend_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (beat_done) begin
                idx_q        <= '0;
                pend_count_q <= beat_count;
            end else if (beat_acc) begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    // Fill buffer storage, written one lane per accepted beat.
    always_ff @(posedge clk) begin
        // NOTE: the lane storage is left unreset; stale lanes are never visible because
        // lanes at or above the count are zeroed when a vector is loaded.
        if (beat_acc) begin
            fill_q[idx_q] <= s_data;
        end
    end

    // Output register: load on a free slot, otherwise drop m_valid once consumed and hold data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
`ifdef VEC_PACK_MASK_EN
            m_mask  <= '0;
`endif
        end else if (load_vec) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_count <= load_count;
`ifdef VEC_PACK_MASK_EN
            m_mask  <= load_mask;
`endif
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_operand_packer.sv
// tb_vec_operand_packer
//   Directed bench for vec_operand_packer (WIDTH=32, N=8). A queue-based model
//   groups accepted elements into expected vectors; a negedge compare process
//   checks every consumed vector against it, and directed steps add literal
//   expectations. Define VEC_PACK_MASK_EN for both files to cover m_mask.
module tb_vec_operand_packer;

    localparam int WIDTH = 32;
    localparam int N     = 8;
    localparam int CW    = $clog2(N) + 1;

    typedef struct {
        logic [N*WIDTH-1:0] data;
        int                 count;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [WIDTH-1:0]     s_data = '0;
    logic                 s_last = 1'b0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic [N*WIDTH-1:0]   m_data;
    logic [CW-1:0]        m_count;
`ifdef VEC_PACK_MASK_EN
    logic [N-1:0]         m_mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vec_t             exp_q [$];
    logic [WIDTH-1:0] cur   [$];

    vec_operand_packer #(.WIDTH(WIDTH), .N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
`ifdef VEC_PACK_MASK_EN
        ,
        .m_mask  (m_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane(input int k);
        return m_data[k*WIDTH +: WIDTH];
    endfunction

    // Model: gather accepted elements; a vector closes on s_last or when N elements are held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur.delete();
            exp_q.delete();
        end else if (s_valid && s_ready) begin
            cur.push_back(s_data);
            if (s_last || cur.size() == N) begin
                vec_t v;
                v.data  = '0;
                v.count = cur.size();
                foreach (cur[i]) v.data[i*WIDTH +: WIDTH] = cur[i];
                exp_q.push_back(v);
                cur.delete();
            end
        end
    end

    // Compare every vector the consumer takes on the coming edge against the model.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            check("vector_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                vec_t v;
                v = exp_q.pop_front();
                for (int k = 0; k < N; k++) begin
                    check($sformatf("model_lane%0d", k), 64'(lane(k)), 64'(v.data[k*WIDTH +: WIDTH]));
                end
                check("model_count", 64'(m_count), 64'(v.count));
`ifdef VEC_PACK_MASK_EN
                check("model_mask", 64'(m_mask), 64'((1 << v.count) - 1));
`endif
            end
        end
    end

    // Offer one element and wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
        int   waited = 0;
        logic acc;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            acc = s_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 200);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: element 0x%0h not accepted within 200 cycles", d);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] ready_pat = 16'hB2E5;

    initial begin
        // Reset state
        #1;
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_m_data", 64'(m_data[63:0]), 64'd0);
        check("reset_m_count", 64'(m_count), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("reset_s_ready", 64'(s_ready), 64'd1);

        // 1: full vector 1..8 with m_ready=1
        for (int i = 1; i <= 8; i++) send_beat(WIDTH'(i), 1'b0);
        check("t1_m_valid", 64'(m_valid), 64'd1);
        check("t1_lane0", 64'(lane(0)), 64'd1);
        check("t1_lane7", 64'(lane(7)), 64'd8);
        check("t1_count", 64'(m_count), 64'd8);
        idle(1);
        check("t1_one_cycle", 64'(m_valid), 64'd0);

        // 2: short vector 5,6,7 then next beat lands in lane 0
        send_beat(32'd5, 1'b0);
        send_beat(32'd6, 1'b0);
        send_beat(32'd7, 1'b1);
        check("t2_lane2", 64'(lane(2)), 64'd7);
        check("t2_lane3", 64'(lane(3)), 64'd0);
        check("t2_lane7", 64'(lane(7)), 64'd0);
        check("t2_count", 64'(m_count), 64'd3);
        send_beat(32'd9, 1'b1);
        check("t2_next_lane0", 64'(lane(0)), 64'd9);
        check("t2_next_count", 64'(m_count), 64'd1);
        idle(1);

        // 3: stalled consumer, 16 beats, then release
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send_beat(WIDTH'(i), 1'b0);
        check("t3_pend_s_ready", 64'(s_ready), 64'd0);
        check("t3_held_valid", 64'(m_valid), 64'd1);
        check("t3_held_lane0", 64'(lane(0)), 64'd1);
        idle(3);
        check("t3_still_held_lane7", 64'(lane(7)), 64'd8);
        m_ready = 1'b1;
        idle(1);
        check("t3_b2b_valid", 64'(m_valid), 64'd1);
        check("t3_b2b_lane0", 64'(lane(0)), 64'd9);
        check("t3_b2b_lane7", 64'(lane(7)), 64'd16);
        check("t3_ready_back", 64'(s_ready), 64'd1);
        idle(1);
        check("t3_drained", 64'(m_valid), 64'd0);

        // 4: reset mid-fill discards partial data
        for (int i = 0; i < 4; i++) send_beat(WIDTH'(32'hF0 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 64'(m_valid), 64'd0);
        check("t4_rst_data", 64'(m_data[63:0]), 64'd0);
        check("t4_rst_count", 64'(m_count), 64'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) send_beat(WIDTH'(32'hA0 + i), 1'b0);
        check("t4_lane0", 64'(lane(0)), 64'hA0);
        check("t4_lane7", 64'(lane(7)), 64'hA7);
        check("t4_count", 64'(m_count), 64'd8);
        idle(1);

        // 5: s_last on the 8th beat gives one vector; then a single-beat vector
        for (int i = 1; i <= 8; i++) send_beat(WIDTH'(32'h10 + i), i == 8);
        check("t5_count", 64'(m_count), 64'd8);
        idle(1);
        check("t5_no_empty_vector", 64'(m_valid), 64'd0);
        send_beat(32'h3, 1'b1);
        check("t5_single_lane0", 64'(lane(0)), 64'd3);
        check("t5_single_lane1", 64'(lane(1)), 64'd0);
        check("t5_single_count", 64'(m_count), 64'd1);
        idle(1);

`ifdef VEC_PACK_MASK_EN
        // 6: mask follows count
        send_beat(32'h1, 1'b0);
        send_beat(32'h2, 1'b0);
        send_beat(32'h3, 1'b1);
        check("t6_mask_short", 64'(m_mask), 64'h07);
        for (int i = 0; i < 8; i++) send_beat(WIDTH'(i), 1'b0);
        check("t6_mask_full", 64'(m_mask), 64'hFF);
        idle(1);
`endif

        // Mixed traffic with an irregular consumer
        fork
            begin
                for (int i = 0; i < 20; i++) send_beat(WIDTH'(32'h100 + i), (i % 5) == 4);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    m_ready = ready_pat[c % 16];
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        m_ready = 1'b1;

        // Drain, bounded
        for (int c = 0; c < 50 && (exp_q.size() != 0 || m_valid); c++) idle(1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_m_valid", 64'(m_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
